// File: rtl/mtm_riscv_pads_pkg.sv
// Shared constants and helpers for the pad-side input conditioning logic.
// Defaults match the board: four buttons, 2-flop synchronisers, ~1 ms debounce at 50 MHz.
package mtm_riscv_pads_pkg;

    localparam int BTN_COUNT           = 4;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 50000;

    // Width of a counter that must hold 0..cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    // Registered per-button state, updated together every clk edge.
    typedef struct packed {
        logic db;
        logic rise;
        logic fall;
        logic flag;
    } btn_state_t;

endpackage

// File: rtl/mtm_riscv_btn_debounce.sv
// One button bit: synchroniser, debounce counter, edge pulses and sticky press flag.
module mtm_riscv_btn_debounce
    import mtm_riscv_pads_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    input  logic flag_clr_i,
    output logic btn_db_o,
    output logic btn_rise_o,
    output logic btn_fall_o,
    output logic press_flag_o
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q, cnt_d;
    btn_state_t             st_q, st_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Any sample equal to the accepted level restarts the count, so glitches never accumulate.
    always_comb begin
        st_d      = st_q;
        st_d.rise = 1'b0;
        st_d.fall = 1'b0;
        cnt_d     = '0;
        if (s != st_q.db) begin
            if (cnt_q == CNT_MAX) begin
                st_d.db   = s;
                st_d.rise = s;
                st_d.fall = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A new press beats a simultaneous clear so no press is ever lost.
        if (st_d.rise)       st_d.flag = 1'b1;
        else if (flag_clr_i) st_d.flag = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            st_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

    assign btn_db_o     = st_q.db;
    assign btn_rise_o   = st_q.rise;
    assign btn_fall_o   = st_q.fall;
    assign press_flag_o = st_q.flag;

endmodule

// File: rtl/mtm_riscv_input_conditioner.sv
// Pad-to-core input conditioning: debounced buttons with pulses/flags and a synchronised UART RX.
module mtm_riscv_input_conditioner
    import mtm_riscv_pads_pkg::*;
#(
    parameter int N_BTN           = BTN_COUNT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             sin_raw,
    input  logic [N_BTN-1:0] flag_clr,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall,
    output logic [N_BTN-1:0] press_flag,
    output logic             sin_sync
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        mtm_riscv_btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk         (clk),
            .rst         (rst),
            .btn_raw_i   (btn_raw[g]),
            .flag_clr_i  (flag_clr[g]),
            .btn_db_o    (btn_db[g]),
            .btn_rise_o  (btn_rise[g]),
            .btn_fall_o  (btn_fall[g]),
            .press_flag_o(press_flag[g])
        );
    end

    // UART line idles high, so the chain resets to ones to avoid a false start bit.
    logic [SYNC_STAGES-1:0] sin_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sin_q <= '1;
        else     sin_q <= {sin_q[SYNC_STAGES-2:0], sin_raw};
    end

    assign sin_sync = sin_q[SYNC_STAGES-1];

endmodule
